// File: rtl/time_set_pkg.sv
// time_set_pkg: shared types and constants for the time/alarm set controller.
//   state_e       - controller states
//   FIELD_*       - edit_field encodings (which digit pair is being edited)
//   HOUR_MAX/MIN_MAX - BCD wrap points
//   bcd_inc_hour/bcd_inc_min - wrapping BCD increments for the two fields
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T_HOUR,
    ST_T_MIN,
    ST_A_HOUR,
    ST_A_MIN,
    ST_LOAD_T,
    ST_LOAD_A,
    ST_STOP
  } state_e;

  localparam logic [1:0] FIELD_HOUR = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // Hours are six bits wide: a 2-bit tens digit over a 4-bit units digit.
  // The >= test also pulls any out-of-range value back to 00.
  function automatic logic [5:0] bcd_inc_hour(input logic [5:0] h);
    if ({2'b00, h} >= HOUR_MAX)  return 6'h00;
    else if (h[3:0] == 4'd9)     return {h[5:4] + 2'd1, 4'd0};
    else                         return {h[5:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc_min(input logic [7:0] m);
    if (m >= MIN_MAX)            return 8'h00;
    else if (m[3:0] == 4'd9)     return {m[7:4] + 4'd1, 4'd0};
    else                         return {m[7:4], m[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// btn_debounce: synchronizer + debounce + rising-edge event for one button.
//   clk      - system clock
//   reset    - asynchronous active-low reset
//   btn_i    - raw asynchronous button level, active-high
//   rise_o   - one-cycle pulse when the debounced level goes 0 -> 1
// A clean press produces rise_o 2 + DEB_CYCLES cycles after the raw edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      // Any sample that agrees with the accepted level restarts the run.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        rise_q  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven HH:MM editor feeding the alarm clock core.
//   clk, reset          - 10 Hz clock, asynchronous active-low reset
//   btn_mode/inc/set    - raw push-buttons, active-high
//   H_in1/H_in0/M_in1/M_in0 - BCD digit bus to the core
//   LD_time/LD_alarm/STOP_al - LD_HOLD-cycle strobes to the core
//   AL_ON               - alarm enable level
//   edit_active/edit_field - edit status for display blinking
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEB_CYCLES   = 2,
  parameter int LD_HOLD      = 10,
  parameter int EDIT_TIMEOUT = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_set,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic       edit_active,
  output logic [1:0] edit_field
);

  localparam int HW = $clog2(LD_HOLD + 1);
  localparam int TW = $clog2(EDIT_TIMEOUT + 1);

  logic ev_mode, ev_inc, ev_set;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .reset(reset), .btn_i(btn_mode), .rise_o(ev_mode)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk(clk), .reset(reset), .btn_i(btn_inc), .rise_o(ev_inc)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk(clk), .reset(reset), .btn_i(btn_set), .rise_o(ev_set)
  );

  state_e        state_q, state_d;
  logic [5:0]    hour_q, hour_d;   // {tens[1:0], units[3:0]}
  logic [7:0]    min_q, min_d;     // {tens[3:0], units[3:0]}
  logic          al_on_q, al_on_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ld_time_q, ld_alarm_q, stop_q;
  logic          edit_active_q;
  logic [1:0]    edit_field_q;
  logic          in_time_edit, in_hour_edit;

  assign in_time_edit = (state_q == ST_T_HOUR) || (state_q == ST_T_MIN);
  assign in_hour_edit = (state_q == ST_T_HOUR) || (state_q == ST_A_HOUR);

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    al_on_d = al_on_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        // set > mode > inc; losers in the same cycle are dropped.
        if (ev_set)        al_on_d = ~al_on_q;
        else if (ev_mode)  state_d = ST_T_HOUR;
        else if (ev_inc)   state_d = ST_STOP;
      end
      ST_T_HOUR, ST_T_MIN, ST_A_HOUR, ST_A_MIN: begin
        if (ev_set || ev_mode || ev_inc) tmo_d = '0;
        if (ev_set) begin
          if (in_time_edit) begin
            state_d = ST_LOAD_T;
          end else begin
            state_d = ST_LOAD_A;
            al_on_d = 1'b1;
          end
        end else if (ev_mode) begin
          unique case (state_q)
            ST_T_HOUR: state_d = ST_T_MIN;
            ST_T_MIN:  state_d = ST_A_HOUR;
            ST_A_HOUR: state_d = ST_A_MIN;
            default:   state_d = ST_IDLE;   // leaving A_MIN aborts
          endcase
        end else if (ev_inc) begin
          if (in_hour_edit) hour_d = bcd_inc_hour(hour_q);
          else              min_d  = bcd_inc_min(min_q);
        end else if (tmo_q == TW'(EDIT_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_LOAD_T, ST_LOAD_A, ST_STOP: begin
        // Events are ignored and digits frozen for the whole hold.
        if (hold_q == HW'(LD_HOLD - 1)) state_d = ST_IDLE;
        else                            hold_d  = hold_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Every state entry starts both counters from zero.
    if (state_d != state_q) begin
      hold_d = '0;
      tmo_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      hour_q        <= '0;
      min_q         <= '0;
      al_on_q       <= 1'b0;
      hold_q        <= '0;
      tmo_q         <= '0;
      ld_time_q     <= 1'b0;
      ld_alarm_q    <= 1'b0;
      stop_q        <= 1'b0;
      edit_active_q <= 1'b0;
      edit_field_q  <= FIELD_HOUR;
    end else begin
      state_q       <= state_d;
      hour_q        <= hour_d;
      min_q         <= min_d;
      al_on_q       <= al_on_d;
      hold_q        <= hold_d;
      tmo_q         <= tmo_d;
      // Strobes decode the next state, so they rise on the first hold cycle
      // and are exclusive by construction.
      ld_time_q     <= (state_d == ST_LOAD_T);
      ld_alarm_q    <= (state_d == ST_LOAD_A);
      stop_q        <= (state_d == ST_STOP);
      edit_active_q <= (state_d == ST_T_HOUR) || (state_d == ST_T_MIN) ||
                       (state_d == ST_A_HOUR) || (state_d == ST_A_MIN);
      edit_field_q  <= ((state_d == ST_T_MIN) || (state_d == ST_A_MIN)) ?
                       FIELD_MIN : FIELD_HOUR;
    end
  end

  assign H_in1       = hour_q[5:4];
  assign H_in0       = hour_q[3:0];
  assign M_in1       = min_q[7:4];
  assign M_in0       = min_q[3:0];
  assign LD_time     = ld_time_q;
  assign LD_alarm    = ld_alarm_q;
  assign STOP_al     = stop_q;
  assign AL_ON       = al_on_q;
  assign edit_active = edit_active_q;
  assign edit_field  = edit_field_q;

endmodule
